// File: rtl/mpmp_fifo_pkg.sv
// rtl/mpmp_fifo_pkg.sv - shared helpers and types for the multi-push/multi-pop FIFO
package mpmp_fifo_pkg;

    function automatic int min_u(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Bits needed to hold a count in 0..n
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_t;

endpackage

// File: rtl/mpmp_fifo_sat_ring_ptr_add.sv
// rtl/mpmp_fifo_sat_ring_ptr_add.sv - combinational (ptr + inc) mod D for a ring of depth D
module ring_ptr_add #(
    parameter int D  = 12,
    parameter int WP = 4,
    parameter int WA = 3
) (
    input  logic [WP-1:0] ptr_i,
    input  logic [WA-1:0] inc_i,
    output logic [WP-1:0] sum_o
);

    logic [WP:0] sum_w;
    logic [WP:0] diff_w;

    // inc never exceeds D, so a single conditional subtract covers every wrap
    assign sum_w  = {1'b0, ptr_i} + (WP+1)'(inc_i);
    assign diff_w = sum_w - (WP+1)'(D);
    assign sum_o  = (sum_w >= (WP+1)'(D)) ? diff_w[WP-1:0] : sum_w[WP-1:0];

endmodule

// File: rtl/mpmp_fifo_sat.sv
// rtl/mpmp_fifo_sat.sv - multi-push/multi-pop FIFO with clamping, sticky error flags and flush
module mpmp_fifo_sat
    import mpmp_fifo_pkg::*;
#(
    parameter int W  = 16,
    parameter int D  = 12,
    parameter int NI = 4,
    parameter int NO = 2,
    parameter int AF = D - NI,
    localparam int WI = cnt_w(NI),
    localparam int WO = cnt_w(NO),
    localparam int WC = cnt_w(D),
    localparam int WP = $clog2(D)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [WI-1:0]   push_i,
    input  logic [NI*W-1:0] push_data_i,
    input  logic [WO-1:0]   pop_i,
    output logic [NO*W-1:0] pop_data_o,
    output logic [WI-1:0]   can_push_o,
    output logic [WO-1:0]   can_pop_o,
    output logic [WC-1:0]   used_o,
    output logic [WC-1:0]   free_o,
    output logic            almost_full_o,
    output logic            overflow_o,
    output logic            underflow_o
);

    localparam int NI_CAP = min_u(NI, D);
    localparam int NO_CAP = min_u(NO, D);

    logic [WP-1:0] wr_ptr_q, wr_ptr_d;
    logic [WP-1:0] rd_ptr_q, rd_ptr_d;
    logic [WC-1:0] used_q, used_d;
    err_t          err_q, err_d;
    logic [W-1:0]  mem_q [D];

    logic [WC-1:0] free_w;
    logic [WI-1:0] acc_push;
    logic [WO-1:0] acc_pop;
    logic [WC:0]   used_sum;
    logic [WP-1:0] wr_nxt, rd_nxt;
    logic [WP-1:0] widx [NI];
    logic [WP-1:0] ridx [NO];

    assign free_w     = WC'(D) - used_q;
    assign can_push_o = (free_w >= WC'(NI_CAP)) ? WI'(NI_CAP) : WI'(free_w);
    assign can_pop_o  = (used_q >= WC'(NO_CAP)) ? WO'(NO_CAP) : WO'(used_q);
    assign acc_push   = (push_i > can_push_o) ? can_push_o : push_i;
    assign acc_pop    = (pop_i > can_pop_o) ? can_pop_o : pop_i;
    assign used_sum   = {1'b0, used_q} + (WC+1)'(acc_push) - (WC+1)'(acc_pop);

    assign used_o        = used_q;
    assign free_o        = free_w;
    assign almost_full_o = (32'(used_q) >= 32'(AF));
    assign overflow_o    = err_q.overflow;
    assign underflow_o   = err_q.underflow;

    ring_ptr_add #(.D(D), .WP(WP), .WA(WI)) u_wr_nxt (
        .ptr_i (wr_ptr_q),
        .inc_i (acc_push),
        .sum_o (wr_nxt)
    );

    ring_ptr_add #(.D(D), .WP(WP), .WA(WO)) u_rd_nxt (
        .ptr_i (rd_ptr_q),
        .inc_i (acc_pop),
        .sum_o (rd_nxt)
    );

    for (genvar gi = 0; gi < NI; gi++) begin : g_widx
        ring_ptr_add #(.D(D), .WP(WP), .WA(WI)) u_widx (
            .ptr_i (wr_ptr_q),
            .inc_i (WI'(gi)),
            .sum_o (widx[gi])
        );
    end

    for (genvar gj = 0; gj < NO; gj++) begin : g_ridx
        ring_ptr_add #(.D(D), .WP(WP), .WA(WO)) u_ridx (
            .ptr_i (rd_ptr_q),
            .inc_i (WO'(gj)),
            .sum_o (ridx[gj])
        );
    end

    // Flush wins over any same-cycle push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        err_d    = err_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            used_d   = '0;
            err_d    = '0;
        end else begin
            wr_ptr_d        = wr_nxt;
            rd_ptr_d        = rd_nxt;
            used_d          = used_sum[WC-1:0];
            err_d.overflow  = err_q.overflow  | (push_i > can_push_o);
            err_d.underflow = err_q.underflow | (pop_i > can_pop_o);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush_i && !rst) begin
            for (int i = 0; i < NI; i++) begin
                if (WI'(i) < acc_push) begin
                    mem_q[widx[i]] <= push_data_i[i*W +: W];
                end
            end
        end
    end

    // Lanes beyond the current occupancy read as zero
    always_comb begin
        pop_data_o = '0;
        for (int j = 0; j < NO; j++) begin
            if (WO'(j) < can_pop_o) begin
                pop_data_o[j*W +: W] = mem_q[ridx[j]];
            end
        end
    end

endmodule

// File: tb/tb_mpmp_fifo_sat.sv
// tb/tb_mpmp_fifo_sat.sv - scoreboard bench for mpmp_fifo_sat with directed bursts
module tb_mpmp_fifo_sat;

    localparam int W  = 16;
    localparam int D  = 12;
    localparam int NI = 4;
    localparam int NO = 2;
    localparam int AF = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush_i = 1'b0;
    logic [2:0]      push_i = '0;
    logic [NI*W-1:0] push_data_i = '0;
    logic [1:0]      pop_i = '0;
    logic [NO*W-1:0] pop_data_o;
    logic [2:0]      can_push_o;
    logic [1:0]      can_pop_o;
    logic [3:0]      used_o;
    logic [3:0]      free_o;
    logic            almost_full_o;
    logic            overflow_o;
    logic            underflow_o;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int m_used = 0;

    mpmp_fifo_sat #(.W(W), .D(D), .NI(NI), .NO(NO), .AF(AF)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .push_i        (push_i),
        .push_data_i   (push_data_i),
        .pop_i         (pop_i),
        .pop_data_o    (pop_data_o),
        .can_push_o    (can_push_o),
        .can_pop_o     (can_pop_o),
        .used_o        (used_o),
        .free_o        (free_o),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every consumed lane is matched against the scoreboard, idle lanes must be zero
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !flush_i) begin
                for (int j = 0; j < NO; j++) begin
                    if (j < int'(can_pop_o) && j < int'(pop_i)) begin
                        if (exp_q.size() == 0) begin
                            chk("pop_unexpected", int'(pop_data_o[j*W +: W]), -1);
                        end else begin
                            int e;
                            e = exp_q.pop_front();
                            chk("pop_data", int'(pop_data_o[j*W +: W]), e);
                        end
                    end else if (j >= int'(can_pop_o)) begin
                        chk("pop_lane_zero", int'(pop_data_o[j*W +: W]), 0);
                    end
                end
            end
        end
    end

    // Drive one cycle; the bench model decides what the FIFO accepts from pre-edge occupancy
    task automatic step(input int np, input int base, input int npop, input bit fl);
        int cp, ap, pp;
        push_i  = 3'(np);
        pop_i   = 2'(npop);
        flush_i = fl;
        for (int i = 0; i < NI; i++) push_data_i[i*W +: W] = W'(base + i);
        if (fl) begin
            exp_q.delete();
            m_used = 0;
        end else begin
            cp = (D - m_used < NI) ? D - m_used : NI;
            ap = (np < cp) ? np : cp;
            pp = (m_used < NO) ? m_used : NO;
            pp = (npop < pp) ? npop : pp;
            for (int i = 0; i < ap; i++) exp_q.push_back(base + i);
            m_used = m_used + ap - pp;
        end
        @(posedge clk);
        #1;
        push_i  = '0;
        pop_i   = '0;
        flush_i = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_used", int'(used_o), 0);
        chk("rst_free", int'(free_o), 12);
        chk("rst_can_push", int'(can_push_o), 4);
        chk("rst_can_pop", int'(can_pop_o), 0);
        chk("rst_af", int'(almost_full_o), 0);
        chk("rst_pop_data", int'(pop_data_o == '0), 1);

        // Fill past full with 1..16
        step(4, 1, 0, 0);  chk("fill1_used", int'(used_o), 4);  chk("fill1_af", int'(almost_full_o), 0);
        step(4, 5, 0, 0);  chk("fill2_used", int'(used_o), 8);  chk("fill2_af", int'(almost_full_o), 1);
        step(4, 9, 0, 0);  chk("fill3_used", int'(used_o), 12); chk("fill3_ovf", int'(overflow_o), 0);
        chk("full_can_push", int'(can_push_o), 0);
        step(4, 13, 0, 0); chk("fill4_used", int'(used_o), 12); chk("fill4_ovf", int'(overflow_o), 1);
        for (int k = 0; k < 6; k++) step(0, 0, 2, 0);
        chk("drain_used", int'(used_o), 0);
        chk("drain_udf", int'(underflow_o), 0);
        step(0, 0, 0, 1);
        chk("flush_ovf", int'(overflow_o), 0);

        // Wrap-around: both pointers cross index 11 -> 0
        step(4, 100, 0, 0); step(4, 104, 0, 0); step(4, 108, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 2, 0);
        chk("wrap_mid_used", int'(used_o), 6);
        step(4, 112, 0, 0);
        chk("wrap_push_used", int'(used_o), 10);
        for (int k = 0; k < 5; k++) step(0, 0, 2, 0);
        chk("wrap_end_used", int'(used_o), 0);
        chk("wrap_scoreboard_empty", exp_q.size(), 0);

        // Simultaneous push and pop at used=11
        step(4, 200, 0, 0); step(4, 204, 0, 0); step(3, 208, 0, 0);
        chk("sim_pre_used", int'(used_o), 11);
        chk("sim_pre_can_push", int'(can_push_o), 1);
        step(4, 211, 2, 0);
        chk("sim_used", int'(used_o), 10);
        chk("sim_ovf", int'(overflow_o), 1);
        chk("sim_udf", int'(underflow_o), 0);
        for (int k = 0; k < 5; k++) step(0, 0, 2, 0);
        chk("sim_drain_used", int'(used_o), 0);
        step(0, 0, 0, 1);

        // Underflow with a single entry
        step(1, 300, 0, 0);
        chk("udf_pre_can_pop", int'(can_pop_o), 1);
        step(0, 0, 2, 0);
        chk("udf_used", int'(used_o), 0);
        chk("udf_flag", int'(underflow_o), 1);
        chk("udf_ovf", int'(overflow_o), 0);

        // Flush priority with both flags set and used=7
        step(4, 400, 0, 0); step(4, 404, 0, 0); step(4, 408, 0, 0);
        step(2, 412, 0, 0);
        step(0, 0, 2, 0); step(0, 0, 2, 0); step(0, 0, 1, 0);
        chk("fl_pre_used", int'(used_o), 7);
        chk("fl_pre_ovf", int'(overflow_o), 1);
        chk("fl_pre_udf", int'(underflow_o), 1);
        step(3, 500, 0, 1);
        chk("fl_used", int'(used_o), 0);
        chk("fl_ovf", int'(overflow_o), 0);
        chk("fl_udf", int'(underflow_o), 0);
        chk("fl_pop_data", int'(pop_data_o == '0), 1);
        step(1, 600, 0, 0);
        chk("fl_after_used", int'(used_o), 1);
        step(0, 0, 1, 0);

        // Asynchronous reset in the middle of a burst
        step(4, 700, 0, 0);
        push_i = 3'd4;
        for (int i = 0; i < NI; i++) push_data_i[i*W +: W] = W'(704 + i);
        #1 rst = 1'b1;
        #1;
        chk("arst_used", int'(used_o), 0);
        chk("arst_can_push", int'(can_push_o), 4);
        chk("arst_pop_data", int'(pop_data_o == '0), 1);
        exp_q.delete();
        m_used = 0;
        push_i = '0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 800, 0, 0);
        chk("arst_after_used", int'(used_o), 1);
        step(0, 0, 1, 0);
        chk("final_used", int'(used_o), 0);
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
